// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end:
//   - base opcode constants used by fetch and the control unit
//   - default reset PC and canonical NOP encoding
//   - fetch-stage state encoding
//   - word-alignment helper for fetch addresses
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] R_TYPE       = 7'h33;
    localparam logic [6:0] I_TYPE_LOGIC = 7'h13;
    localparam logic [6:0] U_TYPE       = 7'h17;
    localparam logic [6:0] I_TYPE_LOAD  = 7'h03;
    localparam logic [6:0] S_TYPE       = 7'h23;
    localparam logic [6:0] B_TYPE       = 7'h63;

    // addi x0,x0,0
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    // start of the text segment
    localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_SKID = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry {instruction, pc} holding register used when a fetched word
// arrives while decode is stalled.
//   clk_i       core clock, rising edge
//   rst_i       asynchronous active-high reset (empties the buffer)
//   wr_i        capture wr_instr_i / wr_pc_i, mark full
//   wr_instr_i  instruction word to store
//   wr_pc_i     address of that word
//   rd_i        entry consumed, mark empty
//   clr_i       flush (wins over wr_i and rd_i)
//   full_o      buffer holds a word
//   instr_o     stored instruction
//   pc_o        stored pc
// -----------------------------------------------------------------------------
module fetch_skid_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [31:0] wr_instr_i,
    input  logic [31:0] wr_pc_i,
    input  logic        rd_i,
    input  logic        clr_i,
    output logic        full_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        full_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (wr_i) begin
            full_q <= 1'b1;
        end else if (rd_i) begin
            full_q <= 1'b0;
        end
    end

    // Payload is only meaningful while full_q is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            instr_q <= wr_instr_i;
            pc_q    <= wr_pc_i;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, issues req/ack fetches to instruction
// memory, and holds the fetched word in the IF/ID register (plus a one-entry
// skid buffer) for decode/control.
//   clk              core clock, rising edge
//   reset            asynchronous active-high reset
//   Branch_Taken_i   redirect request, priority over stall and ack
//   Branch_Target_i  redirect target (bits [1:0] ignored)
//   Stall_i          decode cannot accept; IF/ID holds
//   Imem_Req_o       fetch request (high exactly in REQ)
//   Imem_Addr_o      fetch address (= pc_q)
//   Imem_Ack_i       one-cycle response strobe
//   Imem_Data_i      instruction word, valid with Imem_Ack_i
//   Valid_o          IF/ID holds a valid instruction
//   Instr_o          IF/ID instruction (NOP when not valid)
//   OP_o             Instr_o[6:0]
//   PC_o             address of Instr_o
//   PC_Plus_4_o      PC_o + 4 (mod 2^32)
// -----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Branch_Taken_i,
    input  logic [31:0] Branch_Target_i,
    input  logic        Stall_i,
    output logic        Imem_Req_o,
    output logic [31:0] Imem_Addr_o,
    input  logic        Imem_Ack_i,
    input  logic [31:0] Imem_Data_i,
    output logic        Valid_o,
    output logic [31:0] Instr_o,
    output logic [6:0]  OP_o,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus_4_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;

    logic         skid_wr, skid_rd, skid_clr, skid_full;
    logic [31:0]  skid_instr, skid_pc;
    logic         drain;

    assign drain = valid_q & ~Stall_i;

    fetch_skid_buffer u_skid (
        .clk_i      (clk),
        .rst_i      (reset),
        .wr_i       (skid_wr),
        .wr_instr_i (Imem_Data_i),
        .wr_pc_i    (pc_q),
        .rd_i       (skid_rd),
        .clr_i      (skid_clr),
        .full_o     (skid_full),
        .instr_o    (skid_instr),
        .pc_o       (skid_pc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (Branch_Taken_i) begin
            state_d = FETCH_REQ;
        end else begin
            case (state_q)
                FETCH_IDLE: state_d = FETCH_REQ;
                FETCH_REQ: begin
                    if (Imem_Ack_i && !drop_q && valid_q && Stall_i) begin
                        state_d = FETCH_SKID;
                    end
                end
                FETCH_SKID: begin
                    if (drain) begin
                        state_d = FETCH_REQ;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        Imem_Req_o  = (state_q == FETCH_REQ);
        Imem_Addr_o = pc_q;
    end

    // PC, drop flag, IF/ID and skid control
    always_comb begin
        pc_d     = pc_q;
        drop_d   = drop_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        skid_wr  = 1'b0;
        skid_rd  = 1'b0;
        skid_clr = 1'b0;

        if (Branch_Taken_i) begin
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
            skid_clr = 1'b1;
            pc_d     = word_align(Branch_Target_i);
            // An un-acked request keeps running in memory; its data must be
            // thrown away when it lands. An ack this cycle retires it instead.
            drop_d   = (state_q == FETCH_REQ) && !Imem_Ack_i;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (Imem_Ack_i) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                            if (drain) begin
                                valid_d = 1'b0;
                                instr_d = NOP_INSTR;
                            end
                        end else if (!valid_q || drain) begin
                            valid_d  = 1'b1;
                            instr_d  = Imem_Data_i;
                            pc_out_d = pc_q;
                            pc_d     = pc_q + 32'd4;
                        end else begin
                            skid_wr = 1'b1;
                            pc_d    = pc_q + 32'd4;
                        end
                    end else if (drain) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                FETCH_SKID: begin
                    if (drain && skid_full) begin
                        valid_d  = 1'b1;
                        instr_d  = skid_instr;
                        pc_out_d = skid_pc;
                        skid_rd  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_plus4_d = pc_out_d + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
        end else begin
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign Valid_o     = valid_q;
    assign Instr_o     = instr_q;
    assign OP_o        = instr_q[6:0];
    assign PC_o        = pc_out_q;
    assign PC_Plus_4_o = pc_plus4_q;

endmodule
